// File: rtl/sap_pkg.sv
// Shared definitions for the SAP RAM slice: default widths and the RAM controller state encoding.
package sap_pkg;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } ram_state_t;

endpackage

// File: rtl/ls189_array.sv
// DEPTH x WORD_W storage: synchronous write, combinational read, no reset on the contents.
module ls189_array #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap_ram.sv
// SAP 16x8 RAM with run-mode bus access and a program-mode byte loader.
// Optional even-parity storage and par_err output when RAM_PARITY_EN is defined.
module sap_ram
    import sap_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ce_n,
    input  logic              we_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              prog,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
`ifdef RAM_PARITY_EN
    output logic              par_err,
`endif
    output logic [1:0]        fsm_state
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    ram_state_t        state;
    ram_state_t        state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;

    logic              accept;
    logic              accept_last;
    logic              run_active;
    logic              rd_req;
    logic              wr_req;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] wr_data;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    // Loader handshake: a byte transfers on a rising edge where ld_valid && ld_ready.
    // ld_ready is high only in LOAD with prog still asserted, so an abort cycle never
    // advertises readiness it would not honour.
    assign ld_ready    = (state == LOAD) && prog;
    assign accept      = ld_valid && ld_ready;
    assign accept_last = accept && (ptr == ADDR_W'(DEPTH - 1));

    // A rising prog in RUN abandons the current access on that same edge.
    assign run_active = (state == RUN) && !prog;
    assign wr_req     = run_active && !we_n;
    assign rd_req     = run_active && !ce_n && we_n;

    assign busy      = (state == LOAD);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (prog) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (prog) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                end
            end
            LOAD: begin
                if (!prog) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else if (accept) begin
                    ptr_next = ptr + 1'b1;
                    if (accept_last) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!prog) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // Loader and run-mode writes are mutually exclusive by state, so one write port suffices.
    always_comb begin
        mem_we    = accept || wr_req;
        mem_waddr = accept ? ptr : addr;
        wr_data   = accept ? ld_data : bus_in;
    end

`ifdef RAM_PARITY_EN
    assign mem_wdata = {^wr_data, wr_data};
`else
    assign mem_wdata = wr_data;
`endif

    ls189_array #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus_out <= '0;
            bus_oe  <= 1'b0;
            ld_done <= 1'b0;
        end else begin
            if (rd_req) begin
                bus_out <= mem_rdata[DATA_W-1:0];
            end
            bus_oe  <= rd_req;
            ld_done <= accept_last;
        end
    end

`ifdef RAM_PARITY_EN
    // Stored word plus its parity bit XORs to 1 exactly when the even parity is broken.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            par_err <= 1'b0;
        end else if (rd_req) begin
            par_err <= ^mem_rdata;
        end
    end
`endif

endmodule
